// File: rtl/multicycle_control_unit_if.sv
// Bundle between the multi-cycle sequencer and the datapath, decoder and memories.
// The controller takes the master side; the environment takes the slave side.
interface multicycle_control_unit_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   imem_ready;
  logic                   dmem_ready;
  logic                   mem_to_reg;
  logic [1:0]             mem_write_size;
  logic                   branch;
  logic                   jump;
  logic                   jal_or_jalr;
  logic                   decode_error;
  logic                   branch_taken;

  logic                   imem_req;
  logic                   ir_load;
  logic                   alu_out_load;
  logic                   dmem_req;
  logic                   dmem_we;
  logic                   reg_write;
  logic [1:0]             wb_sel;
  logic                   pc_write;
  logic [1:0]             pc_src;
  logic                   halted;
  logic [2:0]             state;
  logic [COUNT_WIDTH-1:0] instret;

  modport master (
    input  imem_ready, dmem_ready, mem_to_reg, mem_write_size, branch, jump,
           jal_or_jalr, decode_error, branch_taken,
    output imem_req, ir_load, alu_out_load, dmem_req, dmem_we, reg_write,
           wb_sel, pc_write, pc_src, halted, state, instret
  );

  modport slave (
    output imem_ready, dmem_ready, mem_to_reg, mem_write_size, branch, jump,
           jal_or_jalr, decode_error, branch_taken,
    input  imem_req, ir_load, alu_out_load, dmem_req, dmem_we, reg_write,
           wb_sel, pc_write, pc_src, halted, state, instret
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a sticky TRAP.
// Outputs are decoded from the state plus the instruction class latched in DECODE.
module multicycle_control_unit #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  multicycle_control_unit_if.master  ctrl
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  logic [2:0]             state_q, state_d;
  logic                   load_q, load_d;
  logic                   store_q, store_d;
  logic                   branch_q, branch_d;
  logic                   jump_q, jump_d;
  logic                   jal_q, jal_d;
  logic [COUNT_WIDTH-1:0] instret_q, instret_d;

  logic       retire;
  logic       imem_req, ir_load, alu_out_load, dmem_req, dmem_we;
  logic       reg_write, pc_write, halted;
  logic [1:0] wb_sel, pc_src;

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    store_d      = store_q;
    branch_d     = branch_q;
    jump_d       = jump_q;
    jal_d        = jal_q;
    retire       = 1'b0;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    alu_out_load = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    halted       = 1'b0;
    wb_sel       = 2'b00;
    pc_src       = 2'b00;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (ctrl.imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ctrl.decode_error) begin
          state_d = S_TRAP;
        end else begin
          load_d   = ctrl.mem_to_reg;
          store_d  = (ctrl.mem_write_size != 2'b00);
          branch_d = ctrl.branch;
          jump_d   = ctrl.jump;
          jal_d    = ctrl.jal_or_jalr;
          state_d  = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_out_load = 1'b1;
        if (load_q || store_q) begin
          state_d = S_MEMORY;
        end else if (jump_q) begin
          state_d = S_WRITEBACK;
        end else if (branch_q) begin
          pc_write = 1'b1;
          pc_src   = ctrl.branch_taken ? 2'b01 : 2'b00;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        // A store takes priority so a malformed load+store class never writes the regfile.
        dmem_req = 1'b1;
        dmem_we  = store_q;
        if (ctrl.dmem_ready) begin
          if (store_q) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        if (load_q) begin
          wb_sel = 2'b01;
        end else if (jump_q) begin
          wb_sel = 2'b10;
        end
        if (jump_q) begin
          pc_src = jal_q ? 2'b01 : 2'b10;
        end
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    instret_d = instret_q + COUNT_WIDTH'(retire);

    // Reset abandons any in-flight access, so no strobe may escape during the reset cycle.
    if (reset_i) begin
      imem_req     = 1'b0;
      ir_load      = 1'b0;
      alu_out_load = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      reg_write    = 1'b0;
      pc_write     = 1'b0;
      halted       = 1'b0;
      wb_sel       = 2'b00;
      pc_src       = 2'b00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_FETCH;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      branch_q  <= 1'b0;
      jump_q    <= 1'b0;
      jal_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      store_q   <= store_d;
      branch_q  <= branch_d;
      jump_q    <= jump_d;
      jal_q     <= jal_d;
      instret_q <= instret_d;
    end
  end

  assign ctrl.imem_req     = imem_req;
  assign ctrl.ir_load      = ir_load;
  assign ctrl.alu_out_load = alu_out_load;
  assign ctrl.dmem_req     = dmem_req;
  assign ctrl.dmem_we      = dmem_we;
  assign ctrl.reg_write    = reg_write;
  assign ctrl.wb_sel       = wb_sel;
  assign ctrl.pc_write     = pc_write;
  assign ctrl.pc_src       = pc_src;
  assign ctrl.halted       = halted;
  assign ctrl.state        = state_q;
  assign ctrl.instret      = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed instructions, trap/reset cases,
// then random instruction mixes with random memory wait states against a phase-list model.
module tb_multicycle_control_unit;

  localparam int CW = 4;

  localparam int C_ALU    = 0;
  localparam int C_LOAD   = 1;
  localparam int C_STORE  = 2;
  localparam int C_BRANCH = 3;
  localparam int C_JAL    = 4;
  localparam int C_JALR   = 5;

  logic clk;
  logic reset;
  int checks;
  int errors;
  logic [CW-1:0] expInstret;

  multicycle_control_unit_if #(.COUNT_WIDTH(CW)) bus ();

  multicycle_control_unit #(.COUNT_WIDTH(CW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .ctrl    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic driveNoise();
    bus.imem_ready     = 1'($urandom_range(0, 1));
    bus.dmem_ready     = 1'($urandom_range(0, 1));
    bus.mem_to_reg     = 1'($urandom_range(0, 1));
    bus.mem_write_size = 2'($urandom_range(0, 3));
    bus.branch         = 1'($urandom_range(0, 1));
    bus.jump           = 1'($urandom_range(0, 1));
    bus.jal_or_jalr    = 1'($urandom_range(0, 1));
    bus.decode_error   = 1'($urandom_range(0, 1));
    bus.branch_taken   = 1'($urandom_range(0, 1));
  endtask

  task automatic driveClass(input int cls);
    bus.mem_to_reg     = (cls == C_LOAD);
    bus.mem_write_size = (cls == C_STORE) ? 2'($urandom_range(1, 3)) : 2'b00;
    bus.branch         = (cls == C_BRANCH);
    bus.jump           = (cls == C_JAL) || (cls == C_JALR);
    bus.jal_or_jalr    = (cls == C_JAL) ? 1'b1 :
                         (cls == C_JALR) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.decode_error   = 1'b0;
  endtask

  // Runs one instruction; the expected per-cycle phase list comes from the class and wait counts.
  task automatic applyStimulus(input int cls, input int fetchWait, input int memWait,
                               input bit taken);
    int phaseQ[$];
    int last;
    int memStart;
    bit isMem;
    bit writesReg;
    logic [1:0] expPcSrc;
    logic [1:0] expWbSel;

    isMem     = (cls == C_LOAD) || (cls == C_STORE);
    writesReg = (cls == C_ALU) || (cls == C_LOAD) || (cls == C_JAL) || (cls == C_JALR);
    expPcSrc  = (cls == C_BRANCH) ? (taken ? 2'b01 : 2'b00) :
                (cls == C_JAL) ? 2'b01 : (cls == C_JALR) ? 2'b10 : 2'b00;
    expWbSel  = (cls == C_LOAD) ? 2'b01 :
                ((cls == C_JAL) || (cls == C_JALR)) ? 2'b10 : 2'b00;

    for (int i = 0; i <= fetchWait; i++) phaseQ.push_back(0);
    phaseQ.push_back(1);
    phaseQ.push_back(2);
    memStart = phaseQ.size();
    if (isMem) for (int i = 0; i <= memWait; i++) phaseQ.push_back(3);
    if (writesReg) phaseQ.push_back(4);
    last = phaseQ.size() - 1;

    for (int i = 0; i < phaseQ.size(); i++) begin
      @(negedge clk);
      driveNoise();
      if (phaseQ[i] == 0) bus.imem_ready = (i == fetchWait);
      if (phaseQ[i] == 1) driveClass(cls);
      if (phaseQ[i] == 2) bus.branch_taken = taken;
      if (phaseQ[i] == 3) bus.dmem_ready = (i == memStart + memWait);
      #1;
      checkOutput("state", 32'(bus.state), 32'(phaseQ[i]));
      checkOutput("imem_req", 32'(bus.imem_req), 32'(phaseQ[i] == 0));
      checkOutput("ir_load", 32'(bus.ir_load), 32'((phaseQ[i] == 0) && (i == fetchWait)));
      checkOutput("alu_out_load", 32'(bus.alu_out_load), 32'(phaseQ[i] == 2));
      checkOutput("dmem_req", 32'(bus.dmem_req), 32'(phaseQ[i] == 3));
      if (phaseQ[i] == 3) checkOutput("dmem_we", 32'(bus.dmem_we), 32'(cls == C_STORE));
      checkOutput("pc_write", 32'(bus.pc_write), 32'(i == last));
      checkOutput("reg_write", 32'(bus.reg_write), 32'((i == last) && writesReg));
      checkOutput("halted", 32'(bus.halted), 32'd0);
      checkOutput("instret", 32'(bus.instret), 32'(expInstret));
      if (i == last) begin
        checkOutput("pc_src", 32'(bus.pc_src), 32'(expPcSrc));
        if (writesReg) checkOutput("wb_sel", 32'(bus.wb_sel), 32'(expWbSel));
      end
    end
    expInstret = expInstret + 1'b1;
  endtask

  // Releases reset at a falling edge with imem_ready low so FETCH is held for a full cycle.
  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    #1;
    expInstret = '0;
    checkOutput("post_reset_state", 32'(bus.state), 32'd0);
    checkOutput("post_reset_instret", 32'(bus.instret), 32'd0);
    checkOutput("post_reset_halted", 32'(bus.halted), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    expInstret = '0;
    reset = 1'b1;
    driveNoise();

    repeat (2) @(negedge clk);
    driveNoise();
    #1;
    checkOutput("reset_state", 32'(bus.state), 32'd0);
    checkOutput("reset_instret", 32'(bus.instret), 32'd0);
    checkOutput("reset_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("reset_pc_write", 32'(bus.pc_write), 32'd0);
    checkOutput("reset_halted", 32'(bus.halted), 32'd0);
    checkOutput("reset_wb_sel", 32'(bus.wb_sel), 32'd0);
    checkOutput("reset_pc_src", 32'(bus.pc_src), 32'd0);
    releaseReset();

    applyStimulus(C_ALU, 0, 0, 1'b0);
    applyStimulus(C_LOAD, 0, 3, 1'b0);
    applyStimulus(C_BRANCH, 0, 0, 1'b1);
    applyStimulus(C_BRANCH, 1, 0, 1'b0);
    applyStimulus(C_JALR, 0, 0, 1'b0);
    applyStimulus(C_JAL, 2, 0, 1'b0);
    applyStimulus(C_STORE, 0, 2, 1'b0);
    applyStimulus(C_STORE, 0, 0, 1'b0);

    // Random mix; with a 4-bit counter this also wraps instret several times.
    for (int n = 0; n < 48; n++) begin
      applyStimulus(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Decode error parks the core in TRAP until reset.
    @(negedge clk);
    driveNoise();
    bus.imem_ready = 1'b1;
    #1;
    checkOutput("trap_fetch_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    driveNoise();
    bus.decode_error = 1'b1;
    #1;
    checkOutput("trap_decode_state", 32'(bus.state), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      driveNoise();
      #1;
      checkOutput("trap_state", 32'(bus.state), 32'd5);
      checkOutput("trap_halted", 32'(bus.halted), 32'd1);
      checkOutput("trap_imem_req", 32'(bus.imem_req), 32'd0);
      checkOutput("trap_dmem_req", 32'(bus.dmem_req), 32'd0);
      checkOutput("trap_alu_out_load", 32'(bus.alu_out_load), 32'd0);
      checkOutput("trap_reg_write", 32'(bus.reg_write), 32'd0);
      checkOutput("trap_pc_write", 32'(bus.pc_write), 32'd0);
      checkOutput("trap_instret", 32'(bus.instret), 32'(expInstret));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("trap_reset_halted", 32'(bus.halted), 32'd0);
    releaseReset();

    // Reset in MEMORY with dmem_ready high must abandon the store without retiring it.
    @(negedge clk);
    driveNoise();
    bus.imem_ready = 1'b1;
    @(negedge clk);
    driveNoise();
    driveClass(C_STORE);
    @(negedge clk);
    driveNoise();
    @(negedge clk);
    driveNoise();
    bus.dmem_ready = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("memrst_state", 32'(bus.state), 32'd3);
    checkOutput("memrst_pc_write", 32'(bus.pc_write), 32'd0);
    checkOutput("memrst_dmem_req", 32'(bus.dmem_req), 32'd0);
    releaseReset();

    applyStimulus(C_ALU, 0, 0, 1'b0);
    applyStimulus(C_LOAD, 1, 1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("final_instret", 32'(bus.instret), 32'(expInstret));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
